// File: rtl/popcount_expander.sv
// Count-to-word expander: emits a WIDTH-bit word holding exactly min(in_count, WIDTH) ones,
// either as a thermometer from bit 0 or rotated from a round-robin fill pointer.
module popcount_expander #(
  parameter int WIDTH = 64,
  parameter int CW    = $clog2(WIDTH) + 1,
  parameter int PW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW-1:0]    in_count,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word,
  output logic             out_err,
  output logic [PW-1:0]    ptr_o
);

  // Handshake: a beat transfers on a side when valid & ready are both high at a
  // rising edge; valid never waits on ready, and the held word is stable until taken.
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_word_q, out_word_d;
  logic             out_err_q, out_err_d;
  logic [PW-1:0]    ptr_q, ptr_d;

  logic             accept;
  logic [CW-1:0]    n;
  logic [WIDTH-1:0] therm;
  logic [2*WIDTH-1:0] dbl;

  assign in_ready = !out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;

  always_comb begin
    n = (in_count > CW'(WIDTH)) ? CW'(WIDTH) : in_count;
    therm = '0;
    for (int i = 0; i < WIDTH; i++) begin
      therm[i] = (CW'(i) < n);
    end
    // Upper half of the doubled word shifted left is the left rotation by ptr.
    dbl = {therm, therm} << ptr_q;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_word_d  = out_word_q;
    out_err_d   = out_err_q;
    ptr_d       = ptr_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_err_d   = (in_count > CW'(WIDTH));
      if (in_mode) begin
        out_word_d = dbl[2*WIDTH-1:WIDTH];
        ptr_d      = ptr_q + n[PW-1:0];
      end else begin
        out_word_d = therm;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      out_err_q   <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      out_err_q   <= out_err_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_word  = out_word_q;
  assign out_err   = out_err_q;
  assign ptr_o     = ptr_q;

endmodule

// File: tb/tb_popcount_expander.sv
// Bench for popcount_expander: directed vector table, stall/reset sequences and a
// randomized stream scored against a bit-placement model.
module tb_popcount_expander;
  localparam int W  = 64;
  localparam int CW = 7;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_count;
  logic          in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_word;
  logic          out_err;
  logic [PW-1:0] ptr_o;

  popcount_expander dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_count(in_count), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_word(out_word), .out_err(out_err), .ptr_o(ptr_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: place min(cnt,W) ones one at a time, from bit 0 or walking from p.
  function automatic logic [W-1:0] model_word(input int cnt, input bit mode, input int p);
    logic [W-1:0] w;
    int n;
    n = (cnt > W) ? W : cnt;
    w = '0;
    for (int k = 0; k < n; k++) begin
      if (mode) w[(p + k) % W] = 1'b1;
      else      w[k] = 1'b1;
    end
    return w;
  endfunction

  int model_ptr;

  typedef struct {
    int           count;
    bit           mode;
    logic [W-1:0] exp_word;
    bit           exp_err;
    int           exp_ptr;
  } vec_t;

  vec_t vecs[10];

  task automatic send(input int cnt, input bit mode);
    @(negedge clk);
    in_valid = 1'b1;
    in_count = CW'(cnt);
    in_mode  = mode;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Scoreboard for the random stream
  logic [W-1:0] exp_q[$];
  bit           err_q[$];
  int           n_q[$];
  bit           mon_en = 1'b0;
  int           acc_cnt = 0;

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("ptr_track", W'(ptr_o), W'(model_ptr));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", W'(out_valid), W'(0));
        end else begin
          logic [W-1:0] ew;
          bit ee;
          int en;
          ew = exp_q.pop_front();
          ee = err_q.pop_front();
          en = n_q.pop_front();
          chk("rand_word", out_word, ew);
          chk("rand_err", W'(out_err), W'(ee));
          chk("rand_popcount", W'($countones(out_word)), W'(en));
        end
      end
      if (in_valid && in_ready) begin
        int c;
        c = int'(in_count);
        exp_q.push_back(model_word(c, in_mode, model_ptr));
        err_q.push_back(c > W);
        n_q.push_back((c > W) ? W : c);
        if (in_mode) model_ptr = (model_ptr + ((c > W) ? W : c)) % W;
        acc_cnt++;
      end
    end
  end

  initial begin
    logic [W-1:0] a_word, b_word;
    int cyc;

    rst = 1'b1; in_valid = 1'b0; in_count = '0; in_mode = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_out_word", out_word, '0);
    chk("rst_out_err", W'(out_err), W'(0));
    chk("rst_ptr", W'(ptr_o), W'(0));
    chk("rst_in_ready", W'(in_ready), W'(1));

    // Directed vectors applied back-to-back from reset with out_ready=1
    vecs[0] = '{5,   1'b0, 64'h0000_0000_0000_001F, 1'b0, 0};
    vecs[1] = '{60,  1'b1, 64'h0FFF_FFFF_FFFF_FFFF, 1'b0, 60};
    vecs[2] = '{8,   1'b1, 64'hF000_0000_0000_000F, 1'b0, 4};
    vecs[3] = '{0,   1'b0, 64'h0,                   1'b0, 4};
    vecs[4] = '{64,  1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4};
    vecs[5] = '{100, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4};
    vecs[6] = '{100, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4};
    vecs[7] = '{3,   1'b1, 64'h0000_0000_0000_0070, 1'b0, 7};
    vecs[8] = '{65,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 7};
    vecs[9] = '{1,   1'b1, 64'h0000_0000_0000_0080, 1'b0, 8};
    for (int i = 0; i < 10; i++) begin
      send(vecs[i].count, vecs[i].mode);
      chk($sformatf("vec%0d_valid", i), W'(out_valid), W'(1));
      chk($sformatf("vec%0d_word", i), out_word, vecs[i].exp_word);
      chk($sformatf("vec%0d_err", i), W'(out_err), W'(vecs[i].exp_err));
      chk($sformatf("vec%0d_ptr", i), W'(ptr_o), W'(vecs[i].exp_ptr));
    end
    @(posedge clk); #1;
    chk("drain_valid_low", W'(out_valid), W'(0));
    chk("drain_word_hold", out_word, 64'h80);
    model_ptr = 8;

    // Backpressure: hold word A while B waits three cycles
    @(negedge clk) out_ready = 1'b0;
    a_word = model_word(2, 1'b1, model_ptr);
    model_ptr = (model_ptr + 2) % W;
    send(2, 1'b1);
    chk("bp_a_word", out_word, a_word);
    chk("bp_a_ptr", W'(ptr_o), W'(model_ptr));
    b_word = model_word(5, 1'b1, model_ptr);
    @(negedge clk);
    in_valid = 1'b1; in_count = 7'd5; in_mode = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("bp_in_ready_low", W'(in_ready), W'(0));
      chk("bp_word_stable", out_word, a_word);
      chk("bp_ptr_stable", W'(ptr_o), W'(model_ptr));
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 chk("bp_in_ready_release", W'(in_ready), W'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    model_ptr = (model_ptr + 5) % W;
    chk("bp_b_valid", W'(out_valid), W'(1));
    chk("bp_b_word", out_word, b_word);
    chk("bp_b_ptr", W'(ptr_o), W'(model_ptr));
    @(posedge clk); #1;
    chk("bp_b_drained", W'(out_valid), W'(0));

    // Reset while a word is stalled and a new input is being accepted
    @(negedge clk) out_ready = 1'b0;
    send(9, 1'b1);
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_count = 7'd3; in_mode = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b0;
    chk("rstacc_valid", W'(out_valid), W'(0));
    chk("rstacc_ptr", W'(ptr_o), W'(0));
    chk("rstacc_word", out_word, '0);
    @(posedge clk); #1;
    chk("rstacc_no_late_word", W'(out_valid), W'(0));
    model_ptr = 0;

    // Random stream with random backpressure
    mon_en = 1'b1;
    cyc = 0;
    while (acc_cnt < 1000 && cyc < 20000) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_mode   = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: in_count = 7'd0;
        1: in_count = 7'd64;
        2: in_count = 7'($urandom_range(65, 127));
        default: in_count = 7'($urandom_range(0, 64));
      endcase
      out_ready = ($urandom_range(0, 2) != 0);
      cyc++;
    end
    if (acc_cnt < 1000) chk("rand_accept_budget", W'(acc_cnt), W'(1000));
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 100) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    chk("rand_drain_empty", W'(exp_q.size()), W'(0));
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
